// File: rtl/barrel_shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Optional carry/zero flags are enabled by defining SHIFTER_FLAGS_EN.
package barrel_shifter_pkg;

  typedef enum logic [2:0] {
    ModeSll  = 3'b000,
    ModeSrl  = 3'b001,
    ModeSra  = 3'b010,
    ModeRol  = 3'b011,
    ModeRor  = 3'b100,
    ModePass = 3'b101
  } shift_mode_e;

  // left_bit is the operand bit at WIDTH-shamt, right_bit the one at shamt-1.
  function automatic logic stage0_carry(input logic [2:0] mode,
                                        input logic       shamt_nz,
                                        input logic       left_bit,
                                        input logic       right_bit);
    logic c;
    c = 1'b0;
    if (shamt_nz) begin
      case (mode)
        ModeSll, ModeRol:          c = left_bit;
        ModeSrl, ModeSra, ModeRor: c = right_bit;
        default:                   c = 1'b0;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One pipeline stage: conditional shift/rotate by 2^K plus its hold-on-stall register.
// Carry staging exists only when SHIFTER_FLAGS_EN is defined.
module barrel_shift_stage
  import barrel_shifter_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned K       = 0,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               adv,
`ifdef SHIFTER_FLAGS_EN
  input  logic               in_carry,
  output logic               out_carry,
`endif
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [2:0]         in_mode,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_mode,
  output logic [SHAMT_W-1:0] out_shamt
);

  localparam int unsigned S = 1 << K;

  logic               valid_q;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [2:0]         mode_q;
  logic [SHAMT_W-1:0] shamt_q;

  always_comb begin
    data_d = in_data;
    if (in_shamt[K]) begin
      case (in_mode)
        ModeSll: data_d = in_data << S;
        ModeSrl: data_d = in_data >> S;
        ModeSra: data_d = $signed(in_data) >>> S;
        ModeRol: data_d = (in_data << S) | (in_data >> (WIDTH - S));
        ModeRor: data_d = (in_data >> S) | (in_data << (WIDTH - S));
        default: data_d = in_data;
      endcase
    end
  end

  // Payload only loads for valid ops so bubbles never pull X into the pipe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mode_q  <= '0;
      shamt_q <= '0;
    end else if (adv) begin
      valid_q <= in_valid;
      if (in_valid) begin
        data_q  <= data_d;
        mode_q  <= in_mode;
        shamt_q <= in_shamt;
      end
    end
  end

`ifdef SHIFTER_FLAGS_EN
  logic carry_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else if (adv && in_valid) begin
      carry_q <= in_carry;
    end
  end

  assign out_carry = carry_q;
`endif

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_mode  = mode_q;
  assign out_shamt = shamt_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SHAMT_W stages, one op per cycle, global stall on backpressure.
// Define SHIFTER_FLAGS_EN to add the out_carry/out_zero flag outputs.
module pipelined_barrel_shifter
  import barrel_shifter_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef SHIFTER_FLAGS_EN
  output logic               out_carry,
  output logic               out_zero,
`endif
  output logic [WIDTH-1:0]   out_data
);

  // Index 0 is the input side; index k+1 is the register of stage k.
  logic               valid_s [SHAMT_W+1];
  logic [WIDTH-1:0]   data_s  [SHAMT_W+1];
  logic [2:0]         mode_s  [SHAMT_W+1];
  logic [SHAMT_W-1:0] shamt_s [SHAMT_W+1];
  logic               adv;
  logic               unused_tail;

  // Reset term keeps in_ready high while reset is asserted.
  assign adv      = out_ready | ~out_valid | ~rst_n;
  assign in_ready = adv;

  assign valid_s[0] = in_valid;
  assign data_s[0]  = in_data;
  assign mode_s[0]  = in_mode;
  assign shamt_s[0] = in_shamt;

`ifdef SHIFTER_FLAGS_EN
  logic               carry_s [SHAMT_W+1];
  logic [SHAMT_W-1:0] left_idx, right_idx;

  // Wrap-around at shamt = 0 is harmless: stage0_carry forces 0 then.
  assign left_idx   = SHAMT_W'(WIDTH - 32'(in_shamt));
  assign right_idx  = in_shamt - SHAMT_W'(1);
  assign carry_s[0] = stage0_carry(in_mode, |in_shamt, in_data[left_idx], in_data[right_idx]);
`endif

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    barrel_shift_stage #(
      .WIDTH  (WIDTH),
      .K      (k),
      .SHAMT_W(SHAMT_W)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (adv),
`ifdef SHIFTER_FLAGS_EN
      .in_carry (carry_s[k]),
      .out_carry(carry_s[k+1]),
`endif
      .in_valid (valid_s[k]),
      .in_data  (data_s[k]),
      .in_mode  (mode_s[k]),
      .in_shamt (shamt_s[k]),
      .out_valid(valid_s[k+1]),
      .out_data (data_s[k+1]),
      .out_mode (mode_s[k+1]),
      .out_shamt(shamt_s[k+1])
    );
  end

  assign out_valid = valid_s[SHAMT_W];
  assign out_data  = data_s[SHAMT_W];

`ifdef SHIFTER_FLAGS_EN
  assign out_carry = carry_s[SHAMT_W];
  assign out_zero  = out_valid & (out_data == '0);
`endif

  assign unused_tail = ^{mode_s[SHAMT_W], shamt_s[SHAMT_W]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter at WIDTH=8.
// Flag checks are compiled in when SHIFTER_FLAGS_EN is defined.
module tb_pipelined_barrel_shifter;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned SHAMT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_shamt;
  logic [2:0]       in_mode;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef SHIFTER_FLAGS_EN
  logic             out_carry, out_zero;
`endif

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef SHIFTER_FLAGS_EN
    .out_carry(out_carry),
    .out_zero (out_zero),
`endif
    .out_data (out_data)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             carry;
    int unsigned      acc_cyc;
    bit               chk_lat;
  } exp_t;

  exp_t             sb[$];
  int unsigned      n_tests = 0;
  int unsigned      n_fail  = 0;
  int unsigned      cyc     = 0;
  bit               lat_en  = 1'b0;
  bit               stalled = 1'b0;
  logic [WIDTH-1:0] held_data;
`ifdef SHIFTER_FLAGS_EN
  logic             held_carry;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bit-by-bit reference: each result bit is picked from its source position.
  function automatic exp_t model(input logic [7:0] d, input logic [2:0] shv,
                                 input logic [2:0] mode);
    exp_t e;
    int   s;
    s       = int'(shv);
    e.data  = '0;
    e.carry = 1'b0;
    e.acc_cyc = 0;
    e.chk_lat = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] bi, up, dn;
      bi = 3'(i);
      up = 3'(i + s);
      dn = 3'(i - s);
      case (mode)
        3'd0:    e.data[bi] = (i >= s) ? d[dn] : 1'b0;
        3'd1:    e.data[bi] = (i + s < 8) ? d[up] : 1'b0;
        3'd2:    e.data[bi] = (i + s < 8) ? d[up] : d[7];
        3'd3:    e.data[bi] = d[dn];
        3'd4:    e.data[bi] = d[up];
        default: e.data[bi] = d[bi];
      endcase
    end
    if (s != 0) begin
      if (mode == 3'd0 || mode == 3'd3) e.carry = d[3'(8 - s)];
      else if (mode == 3'd1 || mode == 3'd2 || mode == 3'd4) e.carry = d[3'(s - 1)];
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake signals are stable at negedge and describe the coming posedge transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      stalled = 1'b0;
      check_eq("ready_in_reset", 32'(in_ready), 32'd1);
    end else begin
      if (out_valid && !out_ready) begin
        check_eq("stall_in_ready", 32'(in_ready), 32'd0);
        if (stalled) begin
          check_eq("stall_data_stable", 32'(out_data), 32'(held_data));
`ifdef SHIFTER_FLAGS_EN
          check_eq("stall_carry_stable", 32'(out_carry), 32'(held_carry));
`endif
        end
        held_data = out_data;
`ifdef SHIFTER_FLAGS_EN
        held_carry = out_carry;
`endif
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("out_data", 32'(out_data), 32'(e.data));
`ifdef SHIFTER_FLAGS_EN
          check_eq("out_carry", 32'(out_carry), 32'(e.carry));
          check_eq("out_zero", 32'(out_zero), 32'(e.data == '0));
`endif
          if (e.chk_lat) check_eq("latency", cyc - e.acc_cyc, SHAMT_W);
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e = model(in_data, in_shamt, in_mode);
        e.acc_cyc = cyc;
        e.chk_lat = lat_en;
        sb.push_back(e);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds the op until accepted, bounded; leaves in_valid low afterwards.
  task automatic issue(input logic [2:0] mode, input logic [7:0] d, input logic [2:0] sh);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = d;
    in_shamt = sh;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check_eq("issue_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 80 && sb.size() != 0; n++) tick(1);
    check_eq("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_mode   = '0;
    out_ready = 1'b1;
    tick(2);
    check_eq("reset_out_valid", 32'(out_valid), 32'd0);
    check_eq("reset_out_data", 32'(out_data), 32'd0);
    check_eq("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef SHIFTER_FLAGS_EN
    check_eq("reset_out_carry", 32'(out_carry), 32'd0);
    check_eq("reset_out_zero", 32'(out_zero), 32'd0);
`endif
    rst_n = 1'b1;
    tick(1);

    // Directed modes, issued back-to-back.
    lat_en = 1'b1;
    issue(3'b000, 8'h81, 3'd1);
    issue(3'b010, 8'h80, 3'd3);
    issue(3'b001, 8'h80, 3'd3);
    issue(3'b011, 8'h81, 3'd4);
    issue(3'b100, 8'h01, 3'd1);
    issue(3'b110, 8'h5A, 3'd2);
    issue(3'b111, 8'hC3, 3'd0);
    issue(3'b010, 8'h7F, 3'd7);
    drain();

    // Eight back-to-back ops; the latency check proves consecutive delivery.
    for (int i = 0; i < 8; i++) begin
      issue(3'($urandom_range(0, 4)), 8'($urandom), 3'($urandom));
    end
    drain();

    // Backpressure: three ops, then the consumer stalls for five cycles.
    lat_en = 1'b0;
    issue(3'b000, 8'h0F, 3'd2);
    issue(3'b100, 8'hA5, 3'd3);
    issue(3'b010, 8'h96, 3'd1);
    out_ready = 1'b0;
    tick(5);
    check_eq("bp_out_valid", 32'(out_valid), 32'd1);
    check_eq("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    drain();

    // Reset with two ops in flight; nothing from before may emerge.
    lat_en = 1'b1;
    issue(3'b001, 8'hFF, 3'd1);
    issue(3'b011, 8'h3C, 3'd2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_out_data", 32'(out_data), 32'd0);
    tick(4);
    check_eq("midrst_quiet", 32'(out_valid), 32'd0);
    issue(3'b000, 8'h80, 3'd1);
    drain();

    // Random traffic with random backpressure.
    lat_en = 1'b0;
    for (int i = 0; i < 60; i++) begin
      in_valid  = 1'($urandom);
      in_mode   = 3'($urandom);
      in_data   = 8'($urandom);
      in_shamt  = 3'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
